hazard_halt_unit: RTL and testbench
===================================

// Module: hazard_halt_unit
// PURPOSE
//  Consumer of the decoded control bits produced in ID.
//  Generates the pipeline steering signals: PC write-enable, IF/ID write-enable, IF/ID flush and ID/EX bubble.
//  Covers three cases:
//  - load-use stall
//  - taken-branch flush
//  - halt drain (let in-flight instructions retire, then freeze)
//  Sits beside the ID stage. Inputs come from the IF/ID and ID/EX registers and from EX branch resolution.
// PARAMETERS
//  DRAIN_CYCLES  3   cycles spent in DRAIN before HALTED (EX, MEM, WB retire); legal 1..15
//  CNT_W         16  width of the saturating stall-cycle counter
//  REG_AW        5   register-address width
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       synchronous, active-high reset
//  id_rs1        in   REG_AW  rs1 field of the instruction in ID
//  id_rs2        in   REG_AW  rs2 field of the instruction in ID
//  id_use_rs1    in   1       ID instruction reads rs1
//  id_use_rs2    in   1       ID instruction reads rs2
//  id_halt       in   1       decoded Halt for the instruction in ID
//  ex_mem_read   in   1       MemRead held in ID/EX (load in EX)
//  ex_rd         in   REG_AW  destination register held in ID/EX
//  ex_branch_taken in 1       branch in EX resolved taken this cycle
//  resume        in   1       leave HALTED (one-cycle pulse)
//  pc_write      out  1       PC register load enable
//  if_id_write   out  1       IF/ID register load enable
//  if_id_flush   out  1       IF/ID register cleared to NOP on next edge
//  id_ex_bubble  out  1       ID/EX control bits zeroed on next edge
//  halted        out  1       pipeline frozen after halt drain
//  stall_count   out  CNT_W   saturating count of load-use stall cycles
// BEHAVIOUR
//  State register and counters update on posedge clk. Outputs are combinational from state and current inputs (0-cycle latency).
//  FSM states: RUN, DRAIN, HALTED. The drain counter dcnt counts down.
//  Reset (sync) sets state=RUN, dcnt=0, stall_count=0.
//  Output values while reset=1:
//  - pc_write=0, if_id_write=0
//  - if_id_flush=1, id_ex_bubble=1
//  - halted=0
//  load_use = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))
//  RUN, evaluated in priority order:
//  1. ex_branch_taken:
//     - pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1
//     - id_halt and load_use ignored (wrong path)
//  2. load_use:
//     - pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0
//     - stall_count+=1, saturating at 2^CNT_W-1
//  3. id_halt:
//     - pc_write=0, if_id_write=0, id_ex_bubble=1
//     - next state DRAIN, dcnt=DRAIN_CYCLES-1
//  4. otherwise: pc_write=1, if_id_write=1, flush=0, bubble=0
//  DRAIN:
//  - pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0, halted=0
//  - if dcnt==0, next state HALTED; else dcnt-=1
//  - ex_branch_taken, id_halt, load_use and resume are ignored; the Halt itself is never the branch being resolved
//  HALTED:
//  - halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0
//  - resume=1: next state RUN, with if_id_flush=1 in that same cycle
//  - id_halt is still visible in IF/ID, so the flush prevents an immediate re-halt
//  Register x0 never causes a stall (ex_rd==0 masked).
//  stall_count is not cleared by halt or resume; only reset clears it.
//  Reset asserted mid-DRAIN or in HALTED returns to RUN on the next edge.
//  Total DRAIN occupancy is exactly DRAIN_CYCLES cycles. halted rises on cycle DRAIN_CYCLES+1 after the halt cycle.
// TESTING
//  1. Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, for 1 cycle
//     -> pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1
//  2. x0 mask: ex_mem_read=1, ex_rd=0, id_rs1=0, id_use_rs1=1
//     -> no stall; pc_write=1, stall_count unchanged
//  3. Branch over halt: ex_branch_taken=1 and id_halt=1 in the same cycle
//     -> if_id_flush=1, id_ex_bubble=1, state stays RUN, halted stays 0
//  4. Halt drain: id_halt=1 at cycle N, DRAIN_CYCLES=3
//     -> bubbles in cycles N..N+3; halted=1 from N+4 and held for 10 idle cycles
//  5. Resume: pulse resume while halted
//     -> same cycle if_id_flush=1; next cycle halted=0, pc_write=1
//  6. Saturation and reset: CNT_W=2, 5 consecutive load-use cycles
//     -> stall_count=3
//     Then reset in DRAIN -> next cycle state RUN, stall_count=0

Source files
------------

// File: rtl/hazard_halt_unit.sv
// hazard_halt_unit
// Pipeline steering beside the ID stage: load-use stall, taken-branch flush,
// and halt drain (let in-flight instructions retire, then freeze until resume).
// All steering outputs are combinational from the current state and inputs.
module hazard_halt_unit #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16,
  parameter int REG_AW       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_halt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              resume,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Drain counter starts at DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
  localparam logic [3:0] DCNT_INIT = 4'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             load_use;
  logic             rs1_hit;
  logic             rs2_hit;

  // Load-use hazard: a load in EX writes a register the ID instruction reads; x0 never hazards.
  always_comb begin
    rs1_hit  = id_use_rs1 && (ex_rd == id_rs1);
    rs2_hit  = id_use_rs2 && (ex_rd == id_rs2);
    load_use = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

  // Next-state, counters and steering outputs; reset forces the safe flush/bubble pattern.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    stall_count_d = stall_count_q;
    pc_write      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (ex_branch_taken) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (load_use) begin
          id_ex_bubble = 1'b1;
          if (stall_count_q != CNT_MAX) begin
            stall_count_d = stall_count_q + 1'b1;
          end
        end else if (id_halt) begin
          id_ex_bubble = 1'b1;
          state_d      = ST_DRAIN;
          dcnt_d       = DCNT_INIT;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end

      ST_DRAIN: begin
        id_ex_bubble = 1'b1;
        if (dcnt_q == 4'd0) begin
          state_d = ST_HALTED;
        end else begin
          dcnt_d = dcnt_q - 4'd1;
        end
      end

      ST_HALTED: begin
        halted       = 1'b1;
        id_ex_bubble = 1'b1;
        if (resume) begin
          if_id_flush = 1'b1;
          state_d     = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      halted       = 1'b0;
    end
  end

  // State, drain counter and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      dcnt_q        <= 4'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_halt_unit.sv
// tb_hazard_halt_unit
// Directed vector table, hand-written halt/resume/saturation sequences and
// random stimulus against a timestamp-based reference model.
module tb_hazard_halt_unit;

  localparam int DRAIN = 3;
  localparam int SC_MAX16 = 65535;
  localparam int SC_MAX2  = 3;

  typedef struct {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       halt;
    logic       mem_read;
    logic [4:0] rd;
    logic       br;
    logic       res;
  } stim_t;

  typedef struct {
    stim_t s;
    logic  pc;
    logic  ifw;
    logic  fl;
    logic  bub;
    logic  hlt;
    int    sc;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_halt, ex_mem_read, ex_branch_taken, resume;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [15:0] stall_count;
  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_bubble, s_halted;
  logic [1:0]  s_stall_count;

  int checks;
  int failures;

  bit m_valid;
  bit m_in_halt;
  int m_since;
  int m_sc16;
  int m_sc2;

  hazard_halt_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(16), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_halt(id_halt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .resume(resume), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .halted(halted),
    .stall_count(stall_count)
  );

  hazard_halt_unit #(.DRAIN_CYCLES(DRAIN), .CNT_W(2), .REG_AW(5)) dut_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_halt(id_halt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .resume(resume), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_bubble(s_id_ex_bubble), .halted(s_halted),
    .stall_count(s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, use1: 1'b0, use2: 1'b0, halt: 1'b0,
          mem_read: 1'b0, rd: 5'd0, br: 1'b0, res: 1'b0};
    return s;
  endfunction

  function automatic vec_t mk(input stim_t s, input logic pc, input logic ifw, input logic fl,
                              input logic bub, input logic hlt, input int sc);
    vec_t v;
    v.s = s; v.pc = pc; v.ifw = ifw; v.fl = fl; v.bub = bub; v.hlt = hlt; v.sc = sc;
    return v;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0b want=%0b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    reset           = s.rst;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_use_rs1      = s.use1;
    id_use_rs2      = s.use2;
    id_halt         = s.halt;
    ex_mem_read     = s.mem_read;
    ex_rd           = s.rd;
    ex_branch_taken = s.br;
    resume          = s.res;
  endtask

  // Reference model: halt progress is tracked as cycles elapsed since the halt was accepted.
  task automatic model_check(input stim_t s);
    logic e_pc, e_ifw, e_fl, e_bub, e_hlt;
    bit lu;
    lu = s.mem_read && (s.rd != 0) &&
         ((s.use1 && s.rd == s.rs1) || (s.use2 && s.rd == s.rs2));
    e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_hlt = 0;

    if (m_valid) begin
      check_int("model_stall_count", int'(stall_count), m_sc16);
      check_int("model_stall_count_sat", int'(s_stall_count), m_sc2);
    end

    if (s.rst) begin
      e_fl = 1; e_bub = 1;
      m_in_halt = 0; m_sc16 = 0; m_sc2 = 0; m_valid = 1;
    end else if (!m_in_halt) begin
      if (s.br) begin
        e_pc = 1; e_ifw = 1; e_fl = 1; e_bub = 1;
      end else if (lu) begin
        e_bub = 1;
        m_sc16 = (m_sc16 < SC_MAX16) ? m_sc16 + 1 : SC_MAX16;
        m_sc2  = (m_sc2 < SC_MAX2) ? m_sc2 + 1 : SC_MAX2;
      end else if (s.halt) begin
        e_bub = 1;
        m_in_halt = 1; m_since = 0;
      end else begin
        e_pc = 1; e_ifw = 1;
      end
    end else begin
      e_bub = 1;
      if (m_since > DRAIN) begin
        e_hlt = 1;
        if (s.res) begin
          e_fl = 1;
          m_in_halt = 0;
        end
      end
    end
    if (m_in_halt) m_since++;

    check_bit("model_pc_write", pc_write, e_pc);
    check_bit("model_if_id_write", if_id_write, e_ifw);
    check_bit("model_if_id_flush", if_id_flush, e_fl);
    check_bit("model_id_ex_bubble", id_ex_bubble, e_bub);
    check_bit("model_halted", halted, e_hlt);
    check_bit("model_sat_pc_write", s_pc_write, e_pc);
    check_bit("model_sat_if_id_flush", s_if_id_flush, e_fl);
    check_bit("model_sat_id_ex_bubble", s_id_ex_bubble, e_bub);
    check_bit("model_sat_halted", s_halted, e_hlt);
    check_bit("model_sat_if_id_write", s_if_id_write, e_ifw);
  endtask

  // One clock cycle: drive, check on the falling edge, then cross the rising edge.
  task automatic check_output(input vec_t v, input bit use_vec, input string tag);
    apply_stimulus(v.s);
    @(negedge clk);
    if (use_vec) begin
      check_bit({tag, "_pc_write"}, pc_write, v.pc);
      check_bit({tag, "_if_id_write"}, if_id_write, v.ifw);
      check_bit({tag, "_if_id_flush"}, if_id_flush, v.fl);
      check_bit({tag, "_id_ex_bubble"}, id_ex_bubble, v.bub);
      check_bit({tag, "_halted"}, halted, v.hlt);
      if (v.sc >= 0) begin
        check_int({tag, "_stall_count"}, int'(stall_count), v.sc);
        check_int({tag, "_stall_count_sat"}, int'(s_stall_count), (v.sc > 3) ? 3 : v.sc);
      end
    end
    model_check(v.s);
    @(posedge clk);
    #1;
  endtask

  vec_t  tbl[$];
  stim_t s;
  stim_t st_lu;
  stim_t st_halt;

  initial begin
    checks = 0; failures = 0;
    m_valid = 0; m_in_halt = 0; m_since = 0; m_sc16 = 0; m_sc2 = 0;
    apply_stimulus(idle());
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset cycles
    s = idle(); s.rst = 1;
    check_output(mk(s, 0, 0, 1, 1, 0, -1), 1, "reset0");
    s.halt = 1; s.br = 1; s.res = 1;
    check_output(mk(s, 0, 0, 1, 1, 0, 0), 1, "reset1");

    // Directed single-cycle vectors from RUN
    st_lu = idle(); st_lu.mem_read = 1; st_lu.rd = 5; st_lu.rs1 = 5; st_lu.use1 = 1;
    tbl.push_back(mk(st_lu, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(idle(), 1, 1, 0, 0, 0, 1));
    s = idle(); s.mem_read = 1; s.rd = 0; s.rs1 = 0; s.use1 = 1;
    tbl.push_back(mk(s, 1, 1, 0, 0, 0, 1));
    s = idle(); s.mem_read = 1; s.rd = 7; s.rs1 = 3; s.rs2 = 7; s.use1 = 1; s.use2 = 1;
    tbl.push_back(mk(s, 0, 0, 0, 1, 0, 1));
    s.use2 = 0;
    tbl.push_back(mk(s, 1, 1, 0, 0, 0, 2));
    s = st_lu; s.mem_read = 0;
    tbl.push_back(mk(s, 1, 1, 0, 0, 0, 2));
    s = idle(); s.br = 1; s.halt = 1;
    tbl.push_back(mk(s, 1, 1, 1, 1, 0, 2));
    s = st_lu; s.br = 1;
    tbl.push_back(mk(s, 1, 1, 1, 1, 0, 2));
    tbl.push_back(mk(idle(), 1, 1, 0, 0, 0, 2));
    for (int i = 0; i < tbl.size(); i++) begin
      check_output(tbl[i], 1, $sformatf("table%0d", i));
    end

    // Halt drain with ignored noise during DRAIN, then hold HALTED
    st_halt = idle(); st_halt.halt = 1;
    check_output(mk(st_halt, 0, 0, 0, 1, 0, 2), 1, "halt_n");
    s = idle(); s.res = 1;
    check_output(mk(s, 0, 0, 0, 1, 0, -1), 1, "drain1");
    s = st_lu; s.br = 1; s.halt = 1;
    check_output(mk(s, 0, 0, 0, 1, 0, 2), 1, "drain2");
    check_output(mk(idle(), 0, 0, 0, 1, 0, -1), 1, "drain3");
    for (int i = 0; i < 10; i++) begin
      check_output(mk(idle(), 0, 0, 0, 1, 1, -1), 1, $sformatf("halted%0d", i));
    end

    // Resume: flush in the same cycle, running next cycle
    s = st_halt; s.res = 1;
    check_output(mk(s, 0, 0, 1, 1, 1, -1), 1, "resume");
    check_output(mk(idle(), 1, 1, 0, 0, 0, 2), 1, "after_resume");

    // Saturation of the narrow counter, then reset in DRAIN
    for (int i = 0; i < 5; i++) begin
      check_output(mk(st_lu, 0, 0, 0, 1, 0, -1), 1, $sformatf("sat%0d", i));
    end
    check_output(mk(idle(), 1, 1, 0, 0, 0, 7), 1, "sat_done");
    check_output(mk(st_halt, 0, 0, 0, 1, 0, -1), 1, "halt2");
    check_output(mk(idle(), 0, 0, 0, 1, 0, -1), 1, "drain_b1");
    s = idle(); s.rst = 1;
    check_output(mk(s, 0, 0, 1, 1, 0, -1), 1, "reset_in_drain");
    check_output(mk(idle(), 1, 1, 0, 0, 0, 0), 1, "run_after_reset");

    // Randomized stimulus against the reference model
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 99) == 0);
      s.rs1      = 5'($urandom_range(0, 3));
      s.rs2      = 5'($urandom_range(0, 3));
      s.rd       = 5'($urandom_range(0, 3));
      s.use1     = 1'($urandom_range(0, 1));
      s.use2     = 1'($urandom_range(0, 1));
      s.mem_read = ($urandom_range(0, 2) == 0);
      s.halt     = ($urandom_range(0, 15) == 0);
      s.br       = ($urandom_range(0, 7) == 0);
      s.res      = ($urandom_range(0, 3) == 0);
      check_output(mk(s, 0, 0, 0, 0, 0, -1), 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
